mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 237 +++++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit owning the architectural
// HI/LO registers. Multiply-class ops take MULT_CYCLES busy cycles,
// divide-class ops take DIV_CYCLES; MTHI/MTLO write in a single edge.
//
// Ports:
//   clk     in   single clock, all state changes on its rising edge
//   reset   in   synchronous active-high reset
//   start   in   qualifies op/rs_val/rt_val this cycle
//   op      in   0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO
//                6 MADD 7 MADDU 8 MSUB 9 MSUBU, 10-15 no-op
//   rs_val  in   operand A / dividend / MTHI-MTLO data
//   rt_val  in   operand B / divisor
//   cancel  in   aborts an in-flight operation (pipeline flush)
//   busy    out  operation in flight
//   hi, lo  out  architectural HI/LO registers
module mul_div_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = 6;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;

  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_op_mul;
  logic             w_op_div;
  logic             w_launch;
  logic             w_wr_hi;
  logic             w_wr_lo;
  logic             w_commit;

  // Opcode class decode of the incoming request
  always_comb begin
    w_op_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
               (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    w_op_div = (op == OP_DIV) || (op == OP_DIVU);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and counter logic; cancel wins over the final-cycle commit
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (start && (w_op_mul || w_op_div)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = w_op_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
      end
      ST_RUN: begin
        if (cancel || (r_cnt == CW'(1))) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output / control decode
  always_comb begin
    busy     = 1'b0;
    w_launch = 1'b0;
    w_wr_hi  = 1'b0;
    w_wr_lo  = 1'b0;
    w_commit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_launch = start && (w_op_mul || w_op_div);
        w_wr_hi  = start && (op == OP_MTHI);
        w_wr_lo  = start && (op == OP_MTLO);
      end
      ST_RUN: begin
        busy     = 1'b1;
        w_commit = !cancel && (r_cnt == CW'(1));
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Operand capture at launch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op <= '0;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_launch) begin
      r_op <= op;
      r_a  <= rs_val;
      r_b  <= rt_val;
    end
  end

  // Multiplier: operands extended to DW so the truncated product is exact
  logic [DW-1:0] w_sa;
  logic [DW-1:0] w_sb;
  logic [DW-1:0] w_ua;
  logic [DW-1:0] w_ub;
  logic [DW-1:0] w_prod_s;
  logic [DW-1:0] w_prod_u;
  logic [DW-1:0] w_acc;

  always_comb begin
    w_sa     = {{WIDTH{r_a[WIDTH-1]}}, r_a};
    w_sb     = {{WIDTH{r_b[WIDTH-1]}}, r_b};
    w_ua     = {{WIDTH{1'b0}}, r_a};
    w_ub     = {{WIDTH{1'b0}}, r_b};
    w_prod_s = w_sa * w_sb;
    w_prod_u = w_ua * w_ub;
    w_acc    = {r_hi, r_lo};
  end

  // Divider: signed divide runs on magnitudes, then signs are restored.
  // Most-negative / -1 falls out naturally: magnitude 2^(W-1) / 1 keeps
  // the most-negative pattern and remainder 0.
  logic             w_div_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_dvd;
  logic [WIDTH-1:0] w_dvs;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_r_mag;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  always_comb begin
    w_div_signed = (r_op == OP_DIV);
    w_a_neg      = w_div_signed && r_a[WIDTH-1];
    w_b_neg      = w_div_signed && r_b[WIDTH-1];
    w_dvd        = w_a_neg ? (WIDTH'(0) - r_a) : r_a;
    w_dvs        = w_b_neg ? (WIDTH'(0) - r_b) : r_b;
    if (w_dvs == '0) begin
      w_q_mag = '0;
      w_r_mag = '0;
    end else begin
      w_q_mag = w_dvd / w_dvs;
      w_r_mag = w_dvd % w_dvs;
    end
    w_quo = (w_a_neg ^ w_b_neg) ? (WIDTH'(0) - w_q_mag) : w_q_mag;
    w_rem = w_a_neg ? (WIDTH'(0) - w_r_mag) : w_r_mag;
  end

  // Result select for the commit edge
  logic [DW-1:0] w_res;

  always_comb begin
    w_res = w_acc;
    case (r_op)
      OP_MULT:  w_res = w_prod_s;
      OP_MULTU: w_res = w_prod_u;
      OP_MADD:  w_res = w_acc + w_prod_s;
      OP_MADDU: w_res = w_acc + w_prod_u;
      OP_MSUB:  w_res = w_acc - w_prod_s;
      OP_MSUBU: w_res = w_acc - w_prod_u;
      OP_DIV, OP_DIVU: begin
        // Divide by zero: LO all ones, HI keeps the dividend
        if (r_b == '0) w_res = {r_a, {WIDTH{1'b1}}};
        else           w_res = {w_rem, w_quo};
      end
      default: w_res = w_acc;
    endcase
  end

  // Architectural HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      r_hi <= w_res[DW-1:WIDTH];
      r_lo <= w_res[WIDTH-1:0];
    end else begin
      if (w_wr_hi) r_hi <= rs_val;
      if (w_wr_lo) r_lo <= rs_val;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed literal cases plus randomized traffic
// checked every cycle against a behavioural HI/LO model.
module tb_mul_div_unit;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, cancel;
  logic [3:0]  op;
  logic [31:0] rs_val, rt_val;
  logic        busy;
  logic [31:0] hi, lo;

  logic        start8, cancel8;
  logic [3:0]  op8;
  logic [7:0]  rs8, rt8;
  logic        busy8;
  logic [7:0]  hi8, lo8;

  mul_div_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel),
    .busy(busy), .hi(hi), .lo(lo)
  );

  mul_div_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(10)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8),
    .rs_val(rs8), .rt_val(rt8), .cancel(cancel8),
    .busy(busy8), .hi(hi8), .lo(lo8)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int cyc    = 0;

  // Behavioural model state
  bit          m_run = 1'b0;
  int          m_done = 0;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b, m_hi, m_lo;

  // {hi,lo} after an op commits, from plain 64-bit arithmetic
  function automatic logic [63:0] md_result(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, acc, res;
    sa  = $signed(a);
    sb  = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    acc = {h, l};
    res = acc;
    case (o)
      4'd0: res = sa * sb;
      4'd1: res = ua * ub;
      4'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      4'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          ua  = ua / ub + 64'((ua % ub) << 32);
          res = ua;
        end
      end
      4'd6: res = acc + sa * sb;
      4'd7: res = acc + ua * ub;
      4'd8: res = acc - sa * sb;
      4'd9: res = acc - ua * ub;
      default: res = acc;
    endcase
    return res;
  endfunction

  // Model update at each rising edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_run <= 1'b0;
      m_hi  <= 32'd0;
      m_lo  <= 32'd0;
    end else if (m_run) begin
      if (cancel) m_run <= 1'b0;
      else if (cyc == m_done) begin
        {m_hi, m_lo} <= md_result(m_op, m_a, m_b, m_hi, m_lo);
        m_run <= 1'b0;
      end
    end else if (start) begin
      if (op <= 4'd9 && op != 4'd4 && op != 4'd5) begin
        m_run  <= 1'b1;
        m_op   <= op;
        m_a    <= rs_val;
        m_b    <= rt_val;
        m_done <= cyc + ((op == 4'd2 || op == 4'd3) ? int'(DC) : int'(MC));
      end else if (op == 4'd4) m_hi <= rs_val;
      else if (op == 4'd5) m_lo <= rs_val;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (busy !== m_run || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL model_cmp cyc=%0d got busy=%b hi=%h lo=%h want busy=%b hi=%h lo=%h",
                 cyc, busy, hi, lo, m_run, m_hi, m_lo);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start  = 1'b0;
    op     = 4'hF;
  endtask

  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $display("FAIL %s_timeout busy still %b after %0d cycles", name, busy, n);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = 4'hF; rs_val = '0; rt_val = '0;
    start8 = 1'b0; cancel8 = 1'b0; op8 = 4'hF; rs8 = '0; rt8 = '0;

    // Reset state, with start/cancel asserted to show reset wins
    repeat (2) @(negedge clk);
    start = 1'b1; op = 4'd5; rs_val = 32'h1234; cancel = 1'b1;
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);

    // First edge with reset low accepts a start
    reset = 1'b0; cancel = 1'b0; start = 1'b1; op = 4'd5; rs_val = 32'h55;
    chk_en = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'hF;
    chk("first_start_lo", 64'(lo), 64'h55);

    // WIDTH=8 single-cycle multiply: -128 * -1
    start8 = 1'b1; op8 = 4'd0; rs8 = 8'h80; rt8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0; op8 = 4'hF;
    chk("w8_mult_busy", 64'(busy8), 64'd1);
    @(negedge clk);
    chk("w8_mult_busy_done", 64'(busy8), 64'd0);
    chk("w8_mult_hilo", {48'd0, hi8, lo8}, 64'h0080);
    // WIDTH=8 most-negative / -1
    start8 = 1'b1; op8 = 4'd2; rs8 = 8'h80; rt8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0; op8 = 4'hF;
    n = 0;
    while (busy8 === 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("w8_div_cycles", 64'(n), 64'd10);
    chk("w8_div_hilo", {48'd0, hi8, lo8}, 64'h0080);

    // MULT -2 * 3
    issue(4'd0, 32'hFFFF_FFFE, 32'h3);
    chk("mult_busy_first", 64'(busy), 64'd1);
    wait_idle("mult", n);
    chk("mult_cycles", 64'(n), 64'd5);
    chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    // DIV -7 / 2 and DIVU 7 / 0
    issue(4'd2, 32'hFFFF_FFF9, 32'h2);
    wait_idle("div", n);
    chk("div_cycles", 64'(n), 64'd10);
    chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    issue(4'd3, 32'h7, 32'h0);
    wait_idle("divu0", n);
    chk("divu0_hilo", {hi, lo}, 64'h0000_0007_FFFF_FFFF);

    // Most-negative / -1
    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("div_ovf", n);
    chk("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    // MTHI/MTLO then MADD and MSUBU
    issue(4'd4, 32'h0, 32'h0);
    chk("mthi_busy", 64'(busy), 64'd0);
    issue(4'd5, 32'hA, 32'h0);
    chk("mtlo_hilo", {hi, lo}, 64'h0000_0000_0000_000A);
    issue(4'd6, 32'h2, 32'h3);
    wait_idle("madd", n);
    chk("madd_hilo", {hi, lo}, 64'h0000_0000_0000_0010);
    issue(4'd9, 32'h1, 32'h11);
    wait_idle("msubu", n);
    chk("msubu_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);

    // Start during RUN is ignored
    issue(4'd1, 32'h2, 32'h3);
    issue(4'd5, 32'h5, 32'h0);
    wait_idle("multu", n);
    chk("ignored_start_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

    // No-op opcode
    issue(4'd12, 32'h9, 32'h9);
    chk("noop_busy", 64'(busy), 64'd0);

    // Cancel on the 4th busy cycle
    issue(4'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

    // Cancel on the final multiply cycle beats commit
    issue(4'd0, 32'h7, 32'h7);
    repeat (4) @(negedge clk);
    chk("final_cycle_busy", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_final_busy", 64'(busy), 64'd0);
    chk("cancel_final_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

    // Cancel together with start in IDLE: start honoured
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 4'd1; rs_val = 32'h4; rt_val = 32'h5;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; op = 4'hF;
    chk("cancel_start_busy", 64'(busy), 64'd1);
    wait_idle("cancel_start", n);
    chk("cancel_start_hilo", {hi, lo}, 64'h0000_0000_0000_0014);

    // Reset mid-operation
    issue(4'd3, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid_busy", 64'(busy), 64'd0);
    chk("reset_mid_hilo", {hi, lo}, 64'h0);

    // Randomized traffic, checked by the per-cycle compare
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start  = ($urandom % 3) == 0;
      op     = 4'($urandom % 16);
      rs_val = pick();
      rt_val = pick();
      cancel = ($urandom % 25) == 0;
      reset  = ($urandom % 400) == 0;
    end
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; reset = 1'b0;
    repeat (15) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
